// File: rtl/cross_filter5_pkg.sv
// rtl/cross_filter5_pkg.sv - shared pixel width, filter mode codes and sideband type
package cross_filter5_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pix_t;

    localparam logic [1:0] MODE_MED = 2'd0;
    localparam logic [1:0] MODE_MIN = 2'd1;
    localparam logic [1:0] MODE_MAX = 2'd2;
    localparam logic [1:0] MODE_BYP = 2'd3;

    // Per-window control that rides alongside the sorting network
    typedef struct packed {
        logic       vld;
        logic       border;
        logic       eof;
        logic [1:0] mode;
        pix_t       ctr;
    } side_t;

endpackage

// File: rtl/cross_filter5_cmp_swap8.sv
// rtl/cross_filter5_cmp_swap8.sv - combinational compare-exchange of two unsigned pixels
module cmp_swap8
    import cross_filter5_pkg::*;
(
    input  pix_t a,
    input  pix_t b,
    output pix_t lo,
    output pix_t hi
);

    assign lo = (a < b) ? a : b;
    assign hi = (a < b) ? b : a;

endmodule

// File: rtl/cross_filter5.sv
// rtl/cross_filter5.sv - 5-pixel cross median/min/max/bypass filter with border pass-through
module cross_filter5
    import cross_filter5_pkg::*;
#(
    parameter int ROW = 30,
    parameter int COL = 30
) (
    input  logic       vga_clk,
    input  logic       rst_n,
    input  logic [7:0] px1,
    input  logic [7:0] px2,
    input  logic [7:0] px3,
    input  logic [7:0] px4,
    input  logic [7:0] px5,
    input  logic       px_vld,
    input  logic       sof,
    input  logic [1:0] mode,
    output logic [7:0] dout,
    output logic       dout_vld,
    output logic       eof
);

    localparam int RW = $clog2(ROW);
    localparam int CW = $clog2(COL);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);

    logic [RW-1:0] row_cnt;
    logic [CW-1:0] col_cnt;
    logic [1:0]    mode_q;

    logic [RW-1:0] pos_row;
    logic [CW-1:0] pos_col;
    logic [1:0]    cur_mode;
    side_t         s0_side;

    // A sof window is position (0,0) regardless of where the counters were
    assign pos_row  = sof ? '0 : row_cnt;
    assign pos_col  = sof ? '0 : col_cnt;
    assign cur_mode = (px_vld && sof) ? mode : mode_q;

    assign s0_side.vld    = px_vld;
    assign s0_side.border = (pos_row == '0) || (pos_row == ROW_LAST) ||
                            (pos_col == '0) || (pos_col == COL_LAST);
    assign s0_side.eof    = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
    assign s0_side.mode   = cur_mode;
    assign s0_side.ctr    = px3;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt <= '0;
            col_cnt <= '0;
            mode_q  <= MODE_MED;
        end else if (px_vld) begin
            if (sof) begin
                row_cnt <= '0;
                col_cnt <= CW'(1);
                mode_q  <= mode;
            end else if (col_cnt == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + RW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end else if (sof) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end
    end

    // Layer 1: sort pairs (px1,px2) and (px3,px4); px5 waits
    pix_t l0, h0, l1, h1;
    cmp_swap8 u_l1a (.a(px1), .b(px2), .lo(l0), .hi(h0));
    cmp_swap8 u_l1b (.a(px3), .b(px4), .lo(l1), .hi(h1));

    side_t s1_side;
    pix_t  s1_l0, s1_h0, s1_l1, s1_h1, s1_e;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_side <= '0;
            s1_l0   <= '0;
            s1_h0   <= '0;
            s1_l1   <= '0;
            s1_h1   <= '0;
            s1_e    <= '0;
        end else begin
            s1_side <= s0_side;
            s1_l0   <= l0;
            s1_h0   <= h0;
            s1_l1   <= l1;
            s1_h1   <= h1;
            s1_e    <= px5;
        end
    end

    // Layer 2: min and max of the first four; dropping both keeps the median rank
    pix_t lo_lo, lo_hi, hi_lo, hi_hi;
    cmp_swap8 u_l2a (.a(s1_l0), .b(s1_l1), .lo(lo_lo), .hi(lo_hi));
    cmp_swap8 u_l2b (.a(s1_h0), .b(s1_h1), .lo(hi_lo), .hi(hi_hi));

    side_t s2_side;
    pix_t  s2_lo_lo, s2_lo_hi, s2_hi_lo, s2_hi_hi, s2_e;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_side  <= '0;
            s2_lo_lo <= '0;
            s2_lo_hi <= '0;
            s2_hi_lo <= '0;
            s2_hi_hi <= '0;
            s2_e     <= '0;
        end else begin
            s2_side  <= s1_side;
            s2_lo_lo <= lo_lo;
            s2_lo_hi <= lo_hi;
            s2_hi_lo <= hi_lo;
            s2_hi_hi <= hi_hi;
            s2_e     <= s1_e;
        end
    end

    // Final layer: median of the remaining three, plus fold px5 into min/max
    pix_t m_lo, m_hi, a_lo, med, mn, mx;
    pix_t unused_a_hi, unused_b_lo, unused_mn_hi, unused_mx_lo;
    cmp_swap8 u_m3a (.a(s2_lo_hi), .b(s2_hi_lo), .lo(m_lo), .hi(m_hi));
    cmp_swap8 u_m3b (.a(m_hi),     .b(s2_e),     .lo(a_lo), .hi(unused_a_hi));
    cmp_swap8 u_m3c (.a(m_lo),     .b(a_lo),     .lo(unused_b_lo), .hi(med));
    cmp_swap8 u_min (.a(s2_lo_lo), .b(s2_e),     .lo(mn), .hi(unused_mn_hi));
    cmp_swap8 u_max (.a(s2_hi_hi), .b(s2_e),     .lo(unused_mx_lo), .hi(mx));

    pix_t sel;
    always_comb begin
        sel = s2_side.ctr;
        if (!s2_side.border) begin
            case (s2_side.mode)
                MODE_MED: sel = med;
                MODE_MIN: sel = mn;
                MODE_MAX: sel = mx;
                default:  sel = s2_side.ctr;
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            eof      <= 1'b0;
        end else begin
            dout_vld <= s2_side.vld;
            eof      <= s2_side.vld && s2_side.eof;
            if (s2_side.vld) begin
                dout <= sel;
            end
        end
    end

endmodule
